pim_responder: RTL

PIM_RESPONDER -- requirements
Module: pim_responder

---
 rtl/pim_responder_pkg.sv | 12 +
 rtl/pim_sync_fifo.sv | 55 +++++
 rtl/pim_responder.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/pim_responder_pkg.sv
// pim_responder_pkg: shared FSM encoding, transfer-size decode and read latency constant.
package pim_responder_pkg;

    typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_ACK, ST_WRITE, ST_READ} state_e;

    localparam logic [1:0] RD_LATENCY = 2'd0;

    function automatic logic [4:0] size_to_n(input logic [3:0] size);
        return (size == 4'd0) ? 5'd1 : (size == 4'd1) ? 5'd4 : (size == 4'd2) ? 5'd8 : 5'd16;
    endfunction

endpackage

// File: rtl/pim_sync_fifo.sv
// pim_sync_fifo: single-clock FIFO with occupancy count, flush and a zero-latency head.
module pim_sync_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

    // Flush wins over a same-cycle push or pop.
    always_comb begin
        do_push  = push && !full && !flush;
        do_pop   = pop && !empty && !flush;
        wr_ptr_d = flush ? '0 : !do_push ? wr_ptr_q : (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
        rd_ptr_d = flush ? '0 : !do_pop ? rd_ptr_q : (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
        count_d  = flush ? '0 : count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/pim_responder.sv
// pim_responder: PIM target with internal word memory, write/read FIFOs and line-wrapped bursts.
module pim_responder
    import pim_responder_pkg::*;
#(
    parameter int C_MEM_AW      = 8,
    parameter int C_FIFO_DEPTH  = 16,
    parameter int C_ACK_DELAY   = 2,
    parameter int C_INIT_CYCLES = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [31:0] PIM_Addr,
    input  logic        PIM_AddrReq,
    input  logic        PIM_RNW,
    input  logic [3:0]  PIM_Size,
    input  logic        PIM_RdModWr,
    input  logic        PIM_RdFIFO_Pop,
    input  logic        PIM_RdFIFO_Flush,
    input  logic [31:0] PIM_WrFIFO_Data,
    input  logic [3:0]  PIM_WrFIFO_BE,
    input  logic        PIM_WrFIFO_Push,
    input  logic        PIM_WrFIFO_Flush,
    output logic        PIM_AddrAck,
    output logic [31:0] PIM_RdFIFO_Data,
    output logic        PIM_RdFIFO_Empty,
    output logic [3:0]  PIM_RdFIFO_RdWdAddr,
    output logic [1:0]  PIM_RdFIFO_Latency,
    output logic        PIM_WrFIFO_Empty,
    output logic        PIM_WrFIFO_AlmostFull,
    output logic        PIM_InitDone
);
    localparam int CW = 16;
    localparam int FW = $clog2(C_FIFO_DEPTH + 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [C_MEM_AW-1:0] addr_q, addr_d, line_mask, mem_a;
    logic                rnw_q, rnw_d, ack_q, ack_d, done_q, done_d;
    logic [4:0]          n_q, n_d;
    logic [3:0]          off;
    logic                mem_we, wr_pop, rd_push, space_ok, last;
    logic [35:0]         wr_dout, rd_dout;
    logic                wr_empty, wr_full, rd_empty, rd_full;
    logic [FW-1:0]       wr_count, rd_count;
    logic [31:0]         mem_q [2**C_MEM_AW];
    logic                unused;

    assign unused = ^{PIM_RdModWr, wr_full, PIM_Addr[31:C_MEM_AW+2], PIM_Addr[1:0]};

    // Writes start at the line base; reads start at the critical word and wrap in the line.
    always_comb begin
        line_mask = C_MEM_AW'(n_q - 5'd1);
        off       = ((rnw_q ? addr_q[3:0] : 4'd0) + cnt_q[3:0]) & line_mask[3:0];
        mem_a     = (addr_q & ~line_mask) | C_MEM_AW'(off);
        space_ok  = (C_FIFO_DEPTH - int'(rd_count)) >= int'(size_to_n(PIM_Size));
        last      = (cnt_q == CW'(n_q - 5'd1));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rnw_d   = rnw_q;
        n_d     = n_q;
        ack_d   = 1'b0;
        done_d  = done_q;
        mem_we  = 1'b0;
        wr_pop  = 1'b0;
        rd_push = 1'b0;
        case (state_q)
            ST_INIT: begin
                cnt_d   = (cnt_q == CW'(C_INIT_CYCLES - 1)) ? '0 : cnt_q + CW'(1);
                state_d = (cnt_q == CW'(C_INIT_CYCLES - 1)) ? ST_IDLE : ST_INIT;
                done_d  = (cnt_q == CW'(C_INIT_CYCLES - 1));
            end
            ST_IDLE: begin
                if (PIM_AddrReq && (!PIM_RNW || space_ok)) begin
                    addr_d  = PIM_Addr[C_MEM_AW+1:2];
                    rnw_d   = PIM_RNW;
                    n_d     = size_to_n(PIM_Size);
                    cnt_d   = '0;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                ack_d   = (cnt_q == CW'(C_ACK_DELAY - 1));
                cnt_d   = ack_d ? '0 : cnt_q + CW'(1);
                state_d = !ack_d ? ST_ACK : rnw_q ? ST_READ : ST_WRITE;
            end
            ST_WRITE: begin
                wr_pop  = !PIM_WrFIFO_Flush && !wr_empty;
                mem_we  = wr_pop;
                cnt_d   = wr_pop ? cnt_q + CW'(1) : cnt_q;
                state_d = (PIM_WrFIFO_Flush || (wr_pop && last)) ? ST_IDLE : ST_WRITE;
            end
            ST_READ: begin
                rd_push = !PIM_RdFIFO_Flush && !rd_full;
                cnt_d   = rd_push ? cnt_q + CW'(1) : cnt_q;
                state_d = (PIM_RdFIFO_Flush || (rd_push && last)) ? ST_IDLE : ST_READ;
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            addr_q  <= '0;
            rnw_q   <= 1'b0;
            n_q     <= 5'd1;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rnw_q   <= rnw_d;
            n_q     <= n_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
        end
    end

    // Memory has no reset so contents survive a reset mid-transfer.
    always_ff @(posedge sys_clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_dout[32+i]) mem_q[mem_a][8*i +: 8] <= wr_dout[8*i +: 8];
            end
        end
    end

    pim_sync_fifo #(.W(36), .DEPTH(C_FIFO_DEPTH), .CW(FW)) u_wr_fifo (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .push  (PIM_WrFIFO_Push),
        .pop   (wr_pop),
        .flush (PIM_WrFIFO_Flush),
        .din   ({PIM_WrFIFO_BE, PIM_WrFIFO_Data}),
        .dout  (wr_dout),
        .empty (wr_empty),
        .full  (wr_full),
        .count (wr_count)
    );

    pim_sync_fifo #(.W(36), .DEPTH(C_FIFO_DEPTH), .CW(FW)) u_rd_fifo (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .push  (rd_push),
        .pop   (PIM_RdFIFO_Pop),
        .flush (PIM_RdFIFO_Flush),
        .din   ({off, mem_q[mem_a]}),
        .dout  (rd_dout),
        .empty (rd_empty),
        .full  (rd_full),
        .count (rd_count)
    );

    assign PIM_AddrAck           = ack_q;
    assign PIM_InitDone          = done_q;
    assign PIM_RdFIFO_Data       = rd_dout[31:0];
    assign PIM_RdFIFO_RdWdAddr   = rd_dout[35:32];
    assign PIM_RdFIFO_Empty      = rd_empty;
    assign PIM_RdFIFO_Latency    = RD_LATENCY;
    assign PIM_WrFIFO_Empty      = wr_empty;
    assign PIM_WrFIFO_AlmostFull = int'(wr_count) >= C_FIFO_DEPTH - 2;

endmodule
